alu_seq: RTL and testbench

Registered, parametrised successor to the datapath's combinational processing unit. Accepts one operation per cycle through a valid/ready handshake and returns a registered result with carry, zero, negative and overflow flags. Adds subtraction, shifts and rotates, and a multi-cycle unsigned shift-add multiply to the original eight operations. It sits between the register file/accumulator and the flag register of the PDUA datapath.

---
 rtl/alu_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered N-bit ALU with valid/ready intake: single-cycle logic/arith/shift ops
// and an N-iteration unsigned shift-add multiply, with carry/zero/negative/overflow flags.
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dataa,
  input  logic [N-1:0] datab,
  input  logic [3:0]   selop,
  output logic         out_valid,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         zero,
  output logic         neg,
  output logic         ovf
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

  typedef enum logic {IDLE, MUL} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2*N-1:0]  r_acc;
  logic [2*N-1:0]  r_mcand;
  logic [N-1:0]    r_mplier;
  logic            r_valid;
  logic [N-1:0]    r_result;
  logic            r_cout;
  logic            r_zero;
  logic            r_neg;
  logic            r_ovf;

  logic [N:0]      w_sum;
  logic [N-1:0]    w_res;
  logic            w_cout;
  logic            w_ovf;
  logic [2*N-1:0]  w_acc_next;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_valid;
  assign result    = r_result;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign ovf       = r_ovf;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Single-cycle opcode decode; opcode 12 is handled by the multiply sequencer.
  always_comb begin
    w_sum  = '0;
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    case (selop)
      4'd0: w_res = datab;
      4'd1: w_res = ~datab;
      4'd2: w_res = dataa & datab;
      4'd3: w_res = dataa | datab;
      4'd4: w_res = dataa ^ datab;
      4'd5: begin
        w_sum  = {1'b0, dataa} + {1'b0, datab};
        w_res  = w_sum[N-1:0];
        w_cout = w_sum[N];
        w_ovf  = (dataa[N-1] == datab[N-1]) && (w_sum[N-1] != dataa[N-1]);
      end
      4'd6: begin
        w_sum  = {1'b0, datab} + ONE;
        w_res  = w_sum[N-1:0];
        w_cout = w_sum[N];
        w_ovf  = ~datab[N-1] & w_sum[N-1];
      end
      4'd7: begin
        w_sum  = {1'b0, ~datab} + ONE;
        w_res  = w_sum[N-1:0];
        w_cout = w_sum[N];
        w_ovf  = datab[N-1] & w_sum[N-1];
      end
      4'd8: begin
        w_sum  = {1'b0, dataa} + {1'b0, ~datab} + ONE;
        w_res  = w_sum[N-1:0];
        w_cout = w_sum[N];
        w_ovf  = (dataa[N-1] != datab[N-1]) && (w_sum[N-1] != dataa[N-1]);
      end
      4'd9: begin
        w_res  = {dataa[N-2:0], 1'b0};
        w_cout = dataa[N-1];
      end
      4'd10: begin
        w_res  = {1'b0, dataa[N-1:1]};
        w_cout = dataa[0];
      end
      4'd11: begin
        w_res  = {dataa[N-1], dataa[N-1:1]};
        w_cout = dataa[0];
      end
      4'd13: begin
        w_res  = {dataa[N-2:0], dataa[N-1]};
        w_cout = dataa[N-1];
      end
      4'd14: begin
        w_res  = {dataa[0], dataa[N-1:1]};
        w_cout = dataa[0];
      end
      4'd15: w_res = dataa;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (selop == 4'd12) begin
              r_state  <= MUL;
              r_acc    <= '0;
              r_mcand  <= {{N{1'b0}}, dataa};
              r_mplier <= datab;
              r_cnt    <= '0;
            end else begin
              r_result <= w_res;
              r_cout   <= w_cout;
              r_ovf    <= w_ovf;
              r_zero   <= (w_res == '0);
              r_neg    <= w_res[N-1];
              r_valid  <= 1'b1;
            end
          end
        end
        MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[2*N-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[N-1:1]};
          r_cnt    <= r_cnt + CW'(1);
          // Last iteration: publish the low half straight from the adder output.
          if (r_cnt == LAST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_result <= w_acc_next[N-1:0];
            r_cout   <= |w_acc_next[2*N-1:N];
            r_ovf    <= 1'b0;
            r_zero   <= (w_acc_next[N-1:0] == '0);
            r_neg    <= w_acc_next[N-1];
            r_valid  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=8): reset, arithmetic flags, shift burst,
// multiply latency/intake blocking, and reset abort of a multiply.
module tb_alu_seq;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dataa;
  logic [N-1:0] datab;
  logic [3:0]   selop;
  logic         out_valid;
  logic [N-1:0] result;
  logic         cout;
  logic         zero;
  logic         neg;
  logic         ovf;

  int n_assert = 0;
  int n_fail   = 0;

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataa     (dataa),
    .datab     (datab),
    .selop     (selop),
    .out_valid (out_valid),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] r,
                         input logic c, input logic z, input logic n, input logic o);
    chk1({tag, ".out_valid"}, out_valid, 1'b1);
    chk8({tag, ".result"}, result, r);
    chk1({tag, ".cout"}, cout, c);
    chk1({tag, ".zero"}, zero, z);
    chk1({tag, ".neg"}, neg, n);
    chk1({tag, ".ovf"}, ovf, o);
  endtask

  // Present one operation for exactly one rising edge; returns 1 time unit after it.
  task automatic step_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    in_valid = 1'b1;
    selop    = op;
    dataa    = a;
    datab    = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dataa    = '0;
    datab    = '0;
    selop    = '0;
    #12;
    chk1("por.in_ready", in_ready, 1'b1);
    chk1("por.out_valid", out_valid, 1'b0);
    chk8("por.result", result, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    step_op(4'd0, 8'h00, 8'hFF);
    chk_out("passB", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle, observed before any further edge
    #3 rst_n = 1'b0;
    #1;
    chk1("arst.in_ready", in_ready, 1'b1);
    chk1("arst.out_valid", out_valid, 1'b0);
    chk8("arst.result", result, 8'h00);
    chk1("arst.cout", cout, 1'b0);
    chk1("arst.zero", zero, 1'b0);
    chk1("arst.neg", neg, 1'b0);
    chk1("arst.ovf", ovf, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    step_op(4'd5, 8'hFF, 8'h01);
    chk_out("add_ff_01", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step_op(4'd5, 8'h7F, 8'h01);
    chk_out("add_7f_01", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    step_op(4'd7, 8'h00, 8'h80);
    chk_out("neg_80", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    step_op(4'd7, 8'h00, 8'h00);
    chk_out("neg_00", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step_op(4'd8, 8'h05, 8'h07);
    chk_out("sub_05_07", 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
    step_op(4'd8, 8'h80, 8'h01);
    chk_out("sub_80_01", 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1);
    step_op(4'd6, 8'h00, 8'h7F);
    chk_out("inc_7f", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    step_op(4'd6, 8'h00, 8'hFF);
    chk_out("inc_ff", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step_op(4'd1, 8'h00, 8'h0F);
    chk_out("notB", 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
    step_op(4'd2, 8'hF0, 8'h3C);
    chk_out("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    step_op(4'd3, 8'hF0, 8'h3C);
    chk_out("or", 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0);
    step_op(4'd4, 8'hF0, 8'h3C);
    chk_out("xor", 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0);
    step_op(4'd15, 8'h5A, 8'hFF);
    chk_out("passA", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back shift/rotate burst on A = 0x81
    in_valid = 1'b1; dataa = 8'h81; datab = 8'h00;
    selop = 4'd9;  @(posedge clk); #1; chk_out("shl", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    selop = 4'd10; @(posedge clk); #1; chk_out("shr", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    selop = 4'd11; @(posedge clk); #1; chk_out("sar", 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
    selop = 4'd13; @(posedge clk); #1; chk_out("rol", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    selop = 4'd14; @(posedge clk); #1; chk_out("ror", 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk1("idle.out_valid", out_valid, 1'b0);
    chk8("idle.hold", result, 8'hC0);

    // 15 x 17 with op 5 pending on the inputs throughout the multiply
    step_op(4'd12, 8'h0F, 8'h11);
    chk1("mul1.accept.in_ready", in_ready, 1'b0);
    chk1("mul1.accept.out_valid", out_valid, 1'b0);
    in_valid = 1'b1; selop = 4'd5; dataa = 8'h01; datab = 8'h01;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      chk1($sformatf("mul1.busy%0d.in_ready", i), in_ready, 1'b0);
      chk1($sformatf("mul1.busy%0d.out_valid", i), out_valid, 1'b0);
    end
    @(posedge clk); #1;
    chk_out("mul_15x17", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    chk1("mul1.done.in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_out("add_after_mul", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

    step_op(4'd12, 8'h10, 8'h10);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      chk1($sformatf("mul2.busy%0d.out_valid", i), out_valid, 1'b0);
    end
    @(posedge clk); #1;
    chk_out("mul_16x16", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset three cycles into a multiply discards it
    step_op(4'd0, 8'h00, 8'h33);
    chk_out("pre_abort", 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    step_op(4'd12, 8'h03, 8'h05);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk8("abort.result", result, 8'h00);
    chk1("abort.out_valid", out_valid, 1'b0);
    chk1("abort.in_ready", in_ready, 1'b1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk1($sformatf("abort.quiet%0d.out_valid", i), out_valid, 1'b0);
      chk1($sformatf("abort.quiet%0d.in_ready", i), in_ready, 1'b1);
    end
    step_op(4'd0, 8'h00, 8'h5A);
    chk_out("post_abort", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
